// File: rtl/param_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : param_cacheline_adaptor
//  Description : Bridges the last-level cache, which moves one full line per
//                request, to a burst memory port that moves one BURST_W beat
//                per memory acknowledge. It works for any line/burst ratio
//                where BEATS = LINE_W/BURST_W is a power of two and at least 2.
//  Revision    : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   sole clock, rising edge
//    reset      in   synchronous, active-high
//    line_i     in   write line from the LLC, captured at accept
//    line_o     out  assembled read line, meaningful while resp_o=1
//    address_i  in   line address from the LLC, captured at accept
//    read_i     in   LLC read request, held until resp_o
//    write_i    in   LLC write request, held until resp_o
//    resp_o     out  one-cycle completion pulse to the LLC
//    busy_o     out  high whenever the adaptor is not idle
//    burst_i    in   read beat from memory, valid with resp_i
//    burst_o    out  write beat to memory (current beat of the captured line)
//    address_o  out  captured address with the in-line byte offset cleared
//    read_o     out  memory read request
//    write_o    out  memory write request
//    resp_i     in   memory beat acknowledge, one per beat
// ============================================================================
module param_cacheline_adaptor #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   input  logic [ADDR_W-1:0]  address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   output logic               busy_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic [ADDR_W-1:0]  address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
);

   localparam int BEATS = LINE_W / BURST_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam int OFF_W = $clog2(LINE_W / 8);

   // Clears the byte offset within a line so memory always sees an aligned
   // line address.
   localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state;

   logic [CNT_W-1:0]              beat_cnt;
   // Both line stores are kept as beat arrays so a beat is selected directly
   // by beat_cnt; slice 0 is the least significant beat of the line.
   logic [BEATS-1:0][BURST_W-1:0] rd_buf;
   logic [BEATS-1:0][BURST_W-1:0] wr_line;
   logic [ADDR_W-1:0]             addr_q;
   logic                          read_q;
   logic                          write_q;
   logic                          resp_q;
   logic                          busy_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         beat_cnt <= '0;
         rd_buf   <= '0;
         wr_line  <= '0;
         addr_q   <= '0;
         read_q   <= 1'b0;
         write_q  <= 1'b0;
         resp_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         // resp_o is a single-cycle pulse; only the final beat re-asserts it.
         resp_q <= 1'b0;
         case (state)
            S_IDLE: begin
               // Read has priority; a simultaneous write stays pending on the
               // LLC side and is accepted after this read completes.
               if (read_i) begin
                  addr_q   <= address_i & ADDR_MASK;
                  beat_cnt <= '0;
                  read_q   <= 1'b1;
                  busy_q   <= 1'b1;
                  state    <= S_READ;
               end else if (write_i) begin
                  addr_q   <= address_i & ADDR_MASK;
                  wr_line  <= line_i;
                  beat_cnt <= '0;
                  write_q  <= 1'b1;
                  busy_q   <= 1'b1;
                  state    <= S_WRITE;
               end
            end

            S_READ: begin
               // Cycles without resp_i are gaps: nothing moves.
               if (resp_i) begin
                  rd_buf[beat_cnt] <= burst_i;
                  beat_cnt         <= beat_cnt + 1'b1;
                  if (beat_cnt == LAST_BEAT) begin
                     read_q <= 1'b0;
                     resp_q <= 1'b1;
                     state  <= S_DONE;
                  end
               end
            end

            S_WRITE: begin
               if (resp_i) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == LAST_BEAT) begin
                     write_q <= 1'b0;
                     resp_q  <= 1'b1;
                     state   <= S_DONE;
                  end
               end
            end

            S_DONE: begin
               // The LLC drops its request at the edge ending this cycle, so
               // always pass through IDLE before accepting again.
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end

            default: begin
               read_q  <= 1'b0;
               write_q <= 1'b0;
               busy_q  <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   // Outside WRITE the memory side ignores burst_o; presenting beat 0 keeps
   // it stable and independent of the leftover counter value.
   assign burst_o   = (state == S_WRITE) ? wr_line[beat_cnt] : wr_line[0];
   assign line_o    = rd_buf;
   assign address_o = addr_q;
   assign read_o    = read_q;
   assign write_o   = write_q;
   assign resp_o    = resp_q;
   assign busy_o    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_param_cacheline_adaptor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_param_cacheline_adaptor
//  Description : Self-checking bench for param_cacheline_adaptor. Three
//                instances (256/64, 128/32, 512/64) share stimulus buses; a
//                selector routes the active instance's outputs to common
//                observation signals. Expected lines and beats are queued
//                when stimulus is driven and popped when the DUT responds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_cacheline_adaptor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [511:0] line_in;
   logic [31:0]  addr_in;
   logic [63:0]  burst_in;
   logic         resp_in;
   logic [2:0]   rd_req;
   logic [2:0]   wr_req;

   logic [255:0] lo0;
   logic [127:0] lo1;
   logic [511:0] lo2;
   logic [63:0]  bo0;
   logic [31:0]  bo1;
   logic [63:0]  bo2;
   logic [31:0]  ao0, ao1, ao2;
   logic [2:0]   ro, wo, rs, by;

   logic [1:0]   sel;
   logic [511:0] cur_line;
   logic [63:0]  cur_burst;
   logic [31:0]  cur_addr;
   logic         cur_rd, cur_wr, cur_resp, cur_busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [511:0] rdq[$];
   logic [63:0]  wq[$];
   logic [511:0] last_rd[3];

   param_cacheline_adaptor #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) u0 (
      .clk(clk), .reset(reset), .line_i(line_in[255:0]), .line_o(lo0),
      .address_i(addr_in), .read_i(rd_req[0]), .write_i(wr_req[0]),
      .resp_o(rs[0]), .busy_o(by[0]), .burst_i(burst_in[63:0]), .burst_o(bo0),
      .address_o(ao0), .read_o(ro[0]), .write_o(wo[0]), .resp_i(resp_in));

   param_cacheline_adaptor #(.LINE_W(128), .BURST_W(32), .ADDR_W(32)) u1 (
      .clk(clk), .reset(reset), .line_i(line_in[127:0]), .line_o(lo1),
      .address_i(addr_in), .read_i(rd_req[1]), .write_i(wr_req[1]),
      .resp_o(rs[1]), .busy_o(by[1]), .burst_i(burst_in[31:0]), .burst_o(bo1),
      .address_o(ao1), .read_o(ro[1]), .write_o(wo[1]), .resp_i(resp_in));

   param_cacheline_adaptor #(.LINE_W(512), .BURST_W(64), .ADDR_W(32)) u2 (
      .clk(clk), .reset(reset), .line_i(line_in), .line_o(lo2),
      .address_i(addr_in), .read_i(rd_req[2]), .write_i(wr_req[2]),
      .resp_o(rs[2]), .busy_o(by[2]), .burst_i(burst_in), .burst_o(bo2),
      .address_o(ao2), .read_o(ro[2]), .write_o(wo[2]), .resp_i(resp_in));

   always_comb begin
      cur_line  = '0;
      cur_burst = '0;
      cur_addr  = '0;
      case (sel)
         2'd1: begin cur_line = {384'b0, lo1}; cur_burst = {32'b0, bo1}; cur_addr = ao1; end
         2'd2: begin cur_line = lo2;           cur_burst = bo2;          cur_addr = ao2; end
         default: begin cur_line = {256'b0, lo0}; cur_burst = bo0;       cur_addr = ao0; end
      endcase
      cur_rd   = ro[sel];
      cur_wr   = wo[sel];
      cur_resp = rs[sel];
      cur_busy = by[sel];
   end

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // One complete LLC transaction on instance k. pat[i] is resp_i for the
   // i-th active cycle (1 once past patlen).
   task automatic run_txn(input logic [1:0] k, input bit is_rd, input logic [31:0] addr,
                          input logic [511:0] data, input logic [31:0] pat, input int patlen,
                          input bit scramble, input bit stray);
      int lw, bw, beats, offw, exp_lat, cnt, i, idx, bk, cyc;
      logic [511:0] lmask, dm, exp_line;
      logic [63:0]  bmask;
      logic [31:0]  exp_addr;
      bit done, r;
      sel   = k;
      lw    = (k == 2'd1) ? 128 : (k == 2'd2) ? 512 : 256;
      bw    = (k == 2'd1) ? 32 : 64;
      offw  = (k == 2'd1) ? 4 : (k == 2'd2) ? 6 : 5;
      beats = lw / bw;
      lmask = {512{1'b1}} >> (512 - lw);
      bmask = (bw == 64) ? {64{1'b1}} : ((64'd1 << bw) - 64'd1);
      dm    = data & lmask;
      exp_addr = addr & ~((32'd1 << offw) - 32'd1);
      cnt = 0; i = 0;
      while (cnt < beats) begin
         cnt += (i < patlen) ? int'(pat[i]) : 1;
         i++;
      end
      exp_lat = i + 1;

      addr_in = addr;
      if (is_rd) begin
         rd_req[k] = 1'b1;
         rdq.push_back(dm);
      end else begin
         line_in   = data;
         wr_req[k] = 1'b1;
         for (int b = 0; b < beats; b++) wq.push_back(64'(dm >> (b * bw)) & bmask);
      end
      @(negedge clk);
      idx = 0; bk = 0; cyc = 1; done = 1'b0;
      while (!done && cyc < 100) begin
         n_checks++;
         if (cur_rd && cur_wr) begin
            n_fail++;
            $display("FAIL rd_wr_overlap k=%0d: read_o=%0b write_o=%0b, required not both high", k, cur_rd, cur_wr);
         end
         if (cur_resp) begin
            n_checks++;
            if (cyc != exp_lat) begin
               n_fail++;
               $display("FAIL resp_latency k=%0d: got %0d cycles, required %0d", k, cyc, exp_lat);
            end
            n_checks++;
            if (cur_rd !== 1'b0 || cur_wr !== 1'b0 || cur_busy !== 1'b1) begin
               n_fail++;
               $display("FAIL done_outputs k=%0d: read_o=%0b write_o=%0b busy_o=%0b, required 0 0 1", k, cur_rd, cur_wr, cur_busy);
            end
            if (is_rd) begin
               exp_line = rdq.pop_front();
               last_rd[k] = exp_line;
               n_checks++;
               if (cur_line !== exp_line) begin
                  n_fail++;
                  $display("FAIL read_line k=%0d: got %0h, required %0h", k, cur_line, exp_line);
               end
               rd_req[k] = 1'b0;
            end else begin
               n_checks++;
               if (wq.size() != 0) begin
                  n_fail++;
                  $display("FAIL write_beats k=%0d: %0d beats not sent, required 0", k, wq.size());
               end
               wr_req[k] = 1'b0;
            end
            resp_in  = stray;
            burst_in = {$urandom, $urandom};
            done = 1'b1;
         end else begin
            n_checks++;
            if (cur_busy !== 1'b1 || (is_rd ? cur_rd !== 1'b1 : cur_wr !== 1'b1)) begin
               n_fail++;
               $display("FAIL active_req k=%0d cyc=%0d: busy_o=%0b read_o=%0b write_o=%0b, required busy and %s", k, cyc, cur_busy, cur_rd, cur_wr, is_rd ? "read" : "write");
            end
            n_checks++;
            if (cur_addr !== exp_addr) begin
               n_fail++;
               $display("FAIL address_o k=%0d: got %0h, required %0h", k, cur_addr, exp_addr);
            end
            if (!is_rd) begin
               n_checks++;
               if (wq.size() == 0 || cur_burst !== wq[0]) begin
                  n_fail++;
                  $display("FAIL burst_o k=%0d cyc=%0d: got %0h, required %0h", k, cyc, cur_burst, (wq.size() == 0) ? 64'h0 : wq[0]);
               end
            end
            r = (idx < patlen) ? pat[idx] : 1'b1;
            idx++;
            resp_in = r;
            if (r && is_rd) begin
               burst_in = 64'(dm >> (bk * bw)) & bmask;
               bk++;
            end else begin
               burst_in = {$urandom, $urandom};
               if (r) void'(wq.pop_front());
            end
            if (scramble) begin
               addr_in = $urandom;
               line_in = rnd512();
            end
         end
         @(negedge clk);
         cyc++;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout k=%0d: no resp_o within %0d cycles", k, cyc);
         rd_req[k] = 1'b0;
         wr_req[k] = 1'b0;
      end
      resp_in = 1'b0;
      n_checks++;
      if (cur_resp !== 1'b0 || cur_busy !== 1'b0 || cur_rd !== 1'b0 || cur_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after k=%0d: resp_o=%0b busy_o=%0b read_o=%0b write_o=%0b, required all 0", k, cur_resp, cur_busy, cur_rd, cur_wr);
      end
      n_checks++;
      if (cur_line !== last_rd[k]) begin
         n_fail++;
         $display("FAIL read_buffer_kept k=%0d: got %0h, required %0h", k, cur_line, last_rd[k]);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         sel = 2'(k);
         #1;
         n_checks++;
         if (cur_line !== '0 || cur_addr !== '0 || cur_rd !== 1'b0 || cur_wr !== 1'b0 ||
             cur_resp !== 1'b0 || cur_busy !== 1'b0 || cur_burst !== '0) begin
            n_fail++;
            $display("FAIL reset_state k=%0d: line=%0h addr=%0h rd=%0b wr=%0b resp=%0b busy=%0b burst=%0h, required all 0",
                     k, cur_line, cur_addr, cur_rd, cur_wr, cur_resp, cur_busy, cur_burst);
         end
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read_basic();
      run_txn(2'd0, 1'b1, 32'h1234_5678,
              {256'b0, 64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
              32'h0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_write_gaps();
      run_txn(2'd0, 1'b0, 32'h0000_1F40,
              {256'b0, 64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
              32'b1011001, 7, 1'b0, 1'b0);
   endtask

   task automatic test_simultaneous();
      logic [511:0] w;
      w = rnd512();
      line_in   = w;
      wr_req[0] = 1'b1;
      run_txn(2'd0, 1'b1, 32'h0000_8000, rnd512(), 32'h0, 0, 1'b0, 1'b0);
      run_txn(2'd0, 1'b0, 32'h0000_8000, w, 32'b0101, 4, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_read();
      sel       = 2'd0;
      addr_in   = 32'hCAFE_0040;
      rd_req[0] = 1'b1;
      @(negedge clk);
      repeat (2) begin
         resp_in  = 1'b1;
         burst_in = {$urandom, $urandom};
         @(negedge clk);
      end
      reset     = 1'b1;
      resp_in   = 1'b0;
      rd_req[0] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (cur_rd !== 1'b0 || cur_busy !== 1'b0 || cur_line !== '0 || cur_resp !== 1'b0 || cur_addr !== '0) begin
         n_fail++;
         $display("FAIL reset_abort: read_o=%0b busy_o=%0b line_o=%0h resp_o=%0b address_o=%0h, required all 0",
                  cur_rd, cur_busy, cur_line, cur_resp, cur_addr);
      end
      reset = 1'b0;
      for (int k = 0; k < 3; k++) last_rd[k] = '0;
      @(negedge clk);
      run_txn(2'd0, 1'b1, 32'h0BAD_F00D, rnd512(), 32'b110, 3, 1'b0, 1'b0);
   endtask

   task automatic test_stray_and_scramble();
      sel = 2'd0;
      repeat (3) begin
         resp_in  = 1'b1;
         burst_in = {$urandom, $urandom};
         @(negedge clk);
         n_checks++;
         if (cur_busy !== 1'b0 || cur_line !== last_rd[0]) begin
            n_fail++;
            $display("FAIL stray_idle: busy_o=%0b line_o=%0h, required 0 and %0h", cur_busy, cur_line, last_rd[0]);
         end
      end
      resp_in = 1'b0;
      run_txn(2'd0, 1'b1, 32'h7654_3210, rnd512(), 32'b10101, 5, 1'b1, 1'b1);
      run_txn(2'd0, 1'b0, 32'h0F0F_0F0F, rnd512(), 32'b1001, 4, 1'b1, 1'b1);
   endtask

   task automatic test_alt_params();
      run_txn(2'd1, 1'b1, 32'hFFFF_FFFF, rnd512(), 32'h0, 0, 1'b0, 1'b0);
      run_txn(2'd1, 1'b0, 32'h1234_567F, rnd512(), 32'b1101, 4, 1'b1, 1'b0);
      run_txn(2'd2, 1'b1, 32'hFFFF_FFFF, rnd512(), 32'b011, 3, 1'b1, 1'b1);
      run_txn(2'd2, 1'b0, 32'h8765_43BF, rnd512(), 32'h0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_txn(2'd0, 1'b1, 32'h0000_0020, rnd512(), 32'h0, 0, 1'b0, 1'b0);
      run_txn(2'd0, 1'b0, 32'h0000_0040, rnd512(), 32'h0, 0, 1'b0, 1'b0);
      run_txn(2'd0, 1'b1, 32'h0000_0060, rnd512(), 32'h0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      reset    = 1'b1;
      line_in  = '0;
      addr_in  = '0;
      burst_in = '0;
      resp_in  = 1'b0;
      rd_req   = '0;
      wr_req   = '0;
      sel      = 2'd0;
      for (int k = 0; k < 3; k++) last_rd[k] = '0;
      @(negedge clk);
      test_reset();
      test_read_basic();
      test_write_gaps();
      test_simultaneous();
      test_reset_mid_read();
      test_stray_and_scramble();
      test_alt_params();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/param_cacheline_adaptor.md
# param_cacheline_adaptor

Parametrised bridge between the last-level cache (one full line per request) and the burst memory port (one BURST_W beat per memory response). It generalises our fixed 256-bit/4-beat adaptor to any line/burst ratio. Memory may insert gaps between beats, and the request address and write line are latched at accept. A single-cycle line-complete response goes back to the LLC.

## Interface
- LINE_W, 256, cache line width in bits; integer multiple of BURST_W
- BURST_W, 64, memory beat width in bits
- ADDR_W, 32, address width
- BEATS (localparam), LINE_W/BURST_W; must be a power of two, ≥2
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- line_i  in  LINE_W  write line from LLC; sampled at request accept only
- line_o  out  LINE_W  read line to LLC; valid while resp_o=1
- address_i  in  ADDR_W  line address from LLC; sampled at accept
- read_i  in  1  LLC read request, held until resp_o
- write_i  in  1  LLC write request, held until resp_o
- resp_o  out  1  one-cycle completion pulse
- busy_o  out  1  high whenever state ≠ IDLE
- burst_i  in  BURST_W  read beat from memory; valid when resp_i=1
- burst_o  out  BURST_W  write beat to memory; beat[beat_cnt] of latched line
- address_o  out  ADDR_W  latched address, low log2(LINE_W/8) bits forced to 0
- read_o  out  1  memory read request
- write_o  out  1  memory write request
- resp_i  in  1  memory beat acknowledge, one per beat

## Operation
- States: IDLE, READ, WRITE, DONE. Beat counter beat_cnt, width log2(BEATS).
- IDLE: if read_i=1, latch address_i, clear beat_cnt, go to READ. Else if write_i=1, latch address_i and line_i, clear beat_cnt, go to WRITE. read_i and write_i both high: read wins; the write is not lost, since the LLC still holds write_i after resp_o.
- READ: read_o=1. Each cycle with resp_i=1 stores burst_i into line buffer slice [beat_cnt*BURST_W +: BURST_W] and increments beat_cnt. On resp_i with beat_cnt=BEATS-1, go to DONE. Beat order is ascending; slice 0 is the lowest bits.
- WRITE: write_o=1; burst_o = latched line slice [beat_cnt]. Each cycle with resp_i=1 advances beat_cnt. On the last beat, go to DONE.
- DONE: resp_o=1, read_o=write_o=0, line_o holds the full assembled line. Next state is always IDLE.
- resp_i=0 cycles inside READ/WRITE are gaps: hold beat_cnt, buffer and burst_o unchanged; no limit on gap length.
- resp_i in IDLE or DONE is ignored.
- read_i/write_i are sampled only in IDLE. Changes to address_i/line_i after accept have no effect.
- line_o is driven from the line buffer at all times, but is meaningful only during resp_o. A write transaction does not modify the read buffer.
- burst_o outside WRITE is don't-care; it is driven as slice 0 of the latched line.

## Timing
- Reset values: state=IDLE, beat_cnt=0, line buffer=0, latched address=0, latched write line=0. Outputs: read_o=write_o=resp_o=busy_o=0, address_o=0, line_o=0.
- Reset has priority over every other input. Reset mid-transaction aborts immediately: next cycle is IDLE with all outputs at reset values, and the partial line is discarded.
- Accept at edge N (IDLE, request high): read_o/write_o and busy_o are high from cycle N+1.
- Final beat: resp_i=1 at edge M with beat_cnt=BEATS-1. Then resp_o=1 and read_o/write_o=0 in cycle M+1, and state is IDLE in cycle M+2.
- Minimum transaction with no gaps: accept cycle + BEATS beat cycles + 1 DONE cycle. The LLC sees resp_o BEATS+1 cycles after the accept cycle.
- The LLC deasserts read_i/write_i at the edge ending the resp_o cycle. A request still high in the cycle after DONE is a new transaction.
- Back-to-back: a new request may be accepted in the first IDLE cycle after DONE.

## Test plan
- Read, defaults, no gaps: read_i, address_i=0x1234_5678. Memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44. Required: address_o=0x1234_5660; resp_o exactly 5 cycles after accept; line_o=0x44..44_33..33_22..22_11..11.
- Write with gaps: line_i=0xDDDD…_CCCC…_BBBB…_AAAA… (beat 0 = 0xAAAA…). resp_i pattern 1,0,0,1,1,0,1. Required: burst_o shows each beat, lowest first, and holds through the gaps; write_o drops and resp_o pulses exactly once, in the cycle after the 4th resp_i.
- Simultaneous read_i and write_i in IDLE: read executes first. After resp_o, with write_i still high, the write executes. Check read_o and write_o are never high together.
- Reset asserted after the 2nd read beat: next cycle read_o=0, busy_o=0, line_o=0. A fresh read then completes correctly with new data.
- Alternate parameters LINE_W=128, BURST_W=32 (BEATS=4) and LINE_W=512, BURST_W=64 (BEATS=8): verify read and write assemble and split correctly. Check address_o masks 4 and 6 low bits respectively.
- Stray resp_i in IDLE/DONE, and address_i/line_i changed mid-transaction: no state change, and transaction data uses the latched values.
